// File: rtl/frame_payload_capture_if.sv
// frame_payload_capture_if: serial-in / parallel-out bundle for frame_payload_capture
//   master: drives data, sync_found; observes payload, payload_valid, busy, frame_cnt, parity_err
//   slave : the capture block
interface frame_payload_capture_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              data;
    logic              sync_found;
    logic [DATA_W-1:0] payload;
    logic              payload_valid;
    logic              busy;
    logic [CNT_W-1:0]  frame_cnt;
    logic              parity_err;
    modport master (
        output data, sync_found,
        input  payload, payload_valid, busy, frame_cnt, parity_err
    );
    modport slave (
        input  data, sync_found,
        output payload, payload_valid, busy, frame_cnt, parity_err
    );
endinterface

// File: rtl/frame_payload_capture.sv
// frame_payload_capture: after a sync pulse, skips SKIP_BITS bits then shifts in a DATA_W-bit payload LSB-first
//   clk, rst_n (async, active-low)
//   bus.data, bus.sync_found in; bus.payload, bus.payload_valid, bus.busy, bus.frame_cnt, bus.parity_err out
//   Define PARITY_CHECK_EN to expect one even-parity bit after the payload.
module frame_payload_capture #(
    parameter int DATA_W    = 8,
    parameter int SKIP_BITS = 0,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    frame_payload_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SKIP, DATA, PARITY} state_t;
    localparam logic [5:0] SKIP_LAST = 6'(SKIP_BITS > 0 ? SKIP_BITS - 1 : 0);
    localparam logic [5:0] DATA_LAST = 6'(DATA_W - 1);
    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d, payload_q, payload_d;
    logic [CNT_W-1:0]  fcnt_q, fcnt_d;
    logic              valid_q, valid_d, perr_q, perr_d, busy_q;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        payload_d = payload_q;
        fcnt_d    = fcnt_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = bus.sync_found ? (SKIP_BITS > 0 ? SKIP : DATA) : IDLE;
            end
            SKIP: begin
                cnt_d   = cnt_q == SKIP_LAST ? '0 : cnt_q + 6'd1;
                state_d = cnt_q == SKIP_LAST ? DATA : SKIP;
            end
            DATA: begin
                sr_d  = {bus.data, sr_q[DATA_W-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == DATA_LAST) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d   = IDLE;
                    payload_d = sr_d;
                    valid_d   = 1'b1;
                    fcnt_d    = fcnt_q + 1'b1;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                state_d   = IDLE;
                perr_d    = ^{sr_q, bus.data};
                valid_d   = ~perr_d;
                payload_d = perr_d ? payload_q : sr_q;
                fcnt_d    = perr_d ? fcnt_q : fcnt_q + 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            payload_q <= '0;
            fcnt_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            payload_q <= payload_d;
            fcnt_q    <= fcnt_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            busy_q    <= state_d != IDLE;
        end
    end
    assign bus.payload       = payload_q;
    assign bus.payload_valid = valid_q;
    assign bus.busy          = busy_q;
    assign bus.frame_cnt     = fcnt_q;
    assign bus.parity_err    = perr_q;
endmodule

// File: tb/tb_frame_payload_capture.sv
// tb_frame_payload_capture: randomized and directed checks of frame_payload_capture against a history-based model
module tb_frame_payload_capture;
    localparam int DW = 8;
    localparam int SK = 2;
    localparam int CW = 3;
`ifdef PARITY_CHECK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    frame_payload_capture_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
    frame_payload_capture #(.DATA_W(DW), .SKIP_BITS(SK), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    int vectors = 0;
    int miscompares = 0;
    logic hist [0:16383];
    int n = 0;
    bit mbusy = 0;
    int mstart = 0;
    logic [DW-1:0] e_pay = '0;
    logic e_val = 0, e_err = 0;
    logic [CW-1:0] e_cnt = '0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // Frame ends SK+DW+PB edges after the accepted sync; payload is rebuilt from recorded bit history.
    task automatic model(input logic d, input logic s);
        logic [DW-1:0] w;
        hist[n] = d;
        e_val = 0;
        e_err = 0;
        if (mbusy && n == mstart + SK + DW + PB) begin
            for (int i = 0; i < DW; i++) w[i] = hist[mstart + SK + 1 + i];
            if (PB == 1 && ((^w) ^ d)) e_err = 1;
            else begin
                e_pay = w;
                e_val = 1;
                e_cnt = e_cnt + 1'b1;
            end
            mbusy = 0;
        end else if (!mbusy && s) begin
            mbusy = 1;
            mstart = n;
        end
        n++;
    endtask
    task automatic check_all();
        chk("payload", 32'(bus.payload), 32'(e_pay));
        chk("valid", 32'(bus.payload_valid), 32'(e_val));
        chk("busy", 32'(bus.busy), 32'(mbusy));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(e_cnt));
        chk("parity_err", 32'(bus.parity_err), 32'(e_err));
    endtask
    task automatic step(input logic d, input logic s);
        bus.data = d;
        bus.sync_found = s;
        @(posedge clk);
        model(d, s);
        #1;
        check_all();
        @(negedge clk);
    endtask
    task automatic send_frame(input logic [DW-1:0] word, input logic par, input bit mid_sync);
        step(1'($urandom), 1'b1);
        for (int i = 0; i < SK; i++) step(1'($urandom), 1'b0);
        for (int i = 0; i < DW; i++) step(word[i], mid_sync && (i == 2 || i == 4));
        if (PB == 1) step(par, 1'b0);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_payload", 32'(bus.payload), 32'h0);
        chk("rst_valid", 32'(bus.payload_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_cnt", 32'(bus.frame_cnt), 32'h0);
        mbusy = 0;
        e_pay = '0;
        e_val = 0;
        e_err = 0;
        e_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        bus.data = 1'b0;
        bus.sync_found = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_payload", 32'(bus.payload), 32'h0);
        chk("init_busy", 32'(bus.busy), 32'h0);
        chk("init_cnt", 32'(bus.frame_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        send_frame(8'h4D, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t1_payload", 32'(bus.payload), 32'h4D);
        chk("t1_cnt", 32'(bus.frame_cnt), 32'h1);
        send_frame(8'hA5, 1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("t2_payload", 32'(bus.payload), 32'hA5);
`ifdef PARITY_CHECK_EN
        send_frame(8'h4D, 1'b0, 1'b0);
        send_frame(8'h4D, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("t5_payload", 32'(bus.payload), 32'h4D);
        chk("t5_cnt", 32'(bus.frame_cnt), 32'h3);
`endif
        step(1'b1, 1'b1);
        repeat (4) step(1'($urandom), 1'b0);
        do_reset();
        step(1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("t4_payload", 32'(bus.payload), 32'h3C);
        for (int f = 0; f < 10; f++) begin
            logic [DW-1:0] w;
            w = DW'($urandom);
            send_frame(w, ((^w) ^ (f % 3 == 2)), 1'b0);
        end
        for (int c = 0; c < 600; c++) step(1'($urandom), $urandom_range(0, 7) == 0);
        for (int f = 0; f < 12; f++) send_frame(DW'($urandom), 1'($urandom), 1'($urandom));
        repeat (20) step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
